// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - pipeline data-port to req/ack memory bridge with access timeout
module data_mem_bridge #(
  parameter int                    WORD_SIZE = 16,
  parameter int                    TIMEOUT   = 255,
  parameter logic [WORD_SIZE-1:0]  ERR_DATA  = 16'hDEAD
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWData,
  output logic                 MemReq,
  output logic                 MemWe,
  input  logic                 MemAck,
  input  logic [WORD_SIZE-1:0] MemRData,
  output logic                 BusError
);

  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          access;
  logic          timed_out;

  assign access      = ReadData | WriteData;
  assign timed_out   = !MemAck && (cnt == TO_LAST);
  assign DataWaitreq = access && (state != DONE);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (access) state_next = REQ;
      REQ:     if (MemAck || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE and held for the whole REQ phase.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      MemAddr  <= '0;
      MemWData <= '0;
      MemWe    <= 1'b0;
      MemReq   <= 1'b0;
      DataIn   <= '0;
      BusError <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            MemAddr  <= DataAddr;
            MemWData <= DataOut;
            MemWe    <= WriteData;
            MemReq   <= 1'b1;
            cnt      <= '0;
          end
        end
        REQ: begin
          if (MemAck) begin
            if (!MemWe) DataIn <= MemRData;
            MemReq <= 1'b0;
          end else if (timed_out) begin
            if (!MemWe) DataIn <= ERR_DATA;
            MemReq   <= 1'b0;
            BusError <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
